// File: rtl/util_axis_1553_rx_sequencer.sv
// 1553 remote-terminal receive sequencer: filters commands by RT address, frames
// each accepted message into one AXIS packet and terminates malformed ones.
module util_axis_1553_rx_sequencer #(
  parameter int unsigned clock_speed    = 100000000,
  parameter int unsigned rt_address     = 1,
  parameter int unsigned broadcast_en   = 1,
  parameter int unsigned gap_timeout_us = 4
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tuser,
  output logic        s_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        msg_done,
  output logic        msg_error
);

  localparam int unsigned GAP_CYCLES_RAW = (clock_speed / 1000000) * gap_timeout_us;
  localparam int unsigned GAP_CYCLES     = (GAP_CYCLES_RAW == 0) ? 1 : GAP_CYCLES_RAW;
  localparam int unsigned GAP_W          = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CNT_W          = 6;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned USER_W         = 8;

  localparam logic [1:0] SYNC_CMD  = 2'b01;
  localparam logic [1:0] SYNC_DATA = 2'b10;

  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_SYNC    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;

  localparam logic [USER_W-1:0] USER_DATA  = 8'h00;
  localparam logic [USER_W-1:0] USER_RXCMD = 8'h40;
  localparam logic [USER_W-1:0] USER_TXCMD = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_DATA = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [2:0]          err_q, err_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [USER_W-1:0]   m_tuser_q, m_tuser_d;
  logic                m_tlast_q, m_tlast_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                msg_done_q, msg_done_d;
  logic                msg_error_q, msg_error_d;
  logic                rdy_en_q;

  logic                loadable_c;
  logic                s_ready_c;
  logic                accept_c;
  logic [1:0]          w_sync_c;
  logic                w_par_c;
  logic [4:0]          w_addr_c;
  logic                w_tr_c;
  logic [4:0]          w_wc_c;
  logic                addr_match_c;
  logic [GAP_W-1:0]    gap_inc_c;
  logic                unused_bits;

  // Word field decode; subaddress and tuser[7:3] are not needed for framing.
  assign w_sync_c     = s_axis_tuser[1:0];
  assign w_par_c      = s_axis_tuser[2];
  assign w_addr_c     = s_axis_tdata[15:11];
  assign w_tr_c       = s_axis_tdata[10];
  assign w_wc_c       = s_axis_tdata[4:0];
  assign unused_bits  = ^{s_axis_tuser[7:3], s_axis_tdata[9:5]};
  assign addr_match_c = (w_addr_c == 5'(rt_address)) ||
                        ((broadcast_en != 0) && (w_addr_c == 5'd31));

  // rdy_en_q keeps tready low while in reset so every output reads 0 there.
  assign loadable_c    = !m_tvalid_q || m_axis_tready;
  assign s_ready_c     = rdy_en_q && (state_q != ST_ERR) && loadable_c;
  assign accept_c      = s_axis_tvalid && s_ready_c;
  assign gap_inc_c     = gap_q + GAP_W'(1);
  assign s_axis_tready = s_ready_c;

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tlast  = m_tlast_q;
  assign msg_done      = msg_done_q;
  assign msg_error     = msg_error_q;

  // Next-state and output-register load logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    err_d       = err_q;
    m_tdata_d   = m_tdata_q;
    m_tuser_d   = m_tuser_q;
    m_tlast_d   = m_tlast_q;
    m_tvalid_d  = m_tvalid_q && !m_axis_tready;
    msg_done_d  = 1'b0;
    msg_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c && !w_par_c && (w_sync_c == SYNC_CMD) && addr_match_c) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_axis_tdata;
          if (w_tr_c) begin
            m_tuser_d  = USER_TXCMD;
            m_tlast_d  = 1'b1;
            msg_done_d = 1'b1;
          end else begin
            m_tuser_d = USER_RXCMD;
            m_tlast_d = 1'b0;
            cnt_d     = (w_wc_c == 5'd0) ? CNT_W'(32) : CNT_W'(w_wc_c);
            gap_d     = '0;
            state_d   = ST_RX_DATA;
          end
        end
      end

      ST_RX_DATA: begin
        if (accept_c) begin
          gap_d = '0;
          if (w_par_c) begin
            err_d   = ERR_PARITY;
            state_d = ST_ERR;
          end else if (w_sync_c == SYNC_DATA) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis_tdata;
            m_tuser_d  = USER_DATA;
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              m_tlast_d  = 1'b1;
              msg_done_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              m_tlast_d = 1'b0;
            end
          end else begin
            err_d   = ERR_SYNC;
            state_d = ST_ERR;
          end
        end else if (!s_axis_tvalid) begin
          // Only source idleness advances the timer; backpressure holds it.
          gap_d = gap_inc_c;
          if (gap_inc_c == GAP_W'(GAP_CYCLES)) begin
            err_d   = ERR_TIMEOUT;
            state_d = ST_ERR;
          end
        end
      end

      ST_ERR: begin
        if (loadable_c) begin
          m_tvalid_d  = 1'b1;
          m_tdata_d   = '0;
          m_tuser_d   = {2'b11, 3'b000, err_q};
          m_tlast_d   = 1'b1;
          msg_error_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      err_q       <= '0;
      m_tdata_q   <= '0;
      m_tuser_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      msg_done_q  <= 1'b0;
      msg_error_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      m_tdata_q   <= m_tdata_d;
      m_tuser_q   <= m_tuser_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
      msg_done_q  <= msg_done_d;
      msg_error_q <= msg_error_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_util_axis_1553_rx_sequencer.sv
// Scoreboard bench for the 1553 RX sequencer: a message-level model predicts the
// beat stream, a monitor checks every beat and the done/error pulses.
module tb_util_axis_1553_rx_sequencer;

  localparam int GAP = 400;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic [7:0]  s_tuser = '0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic [7:0]  m_tuser;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        msg_done;
  logic        msg_error;

  util_axis_1553_rx_sequencer dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .msg_done      (msg_done),
    .msg_error     (msg_error)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  u;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    lo_until = 0;
  bit    bp_en = 1'b0;

  bit    in_msg = 1'b0;
  int    rem = 0;
  int    idle_acc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void note_fail(string name, logic [31:0] act, logic [31:0] req);
    miscompares++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) note_fail(name, act, req);
  endfunction

  // ---- reference model: message-level framing rules ----
  function automatic void push_beat(logic [15:0] d, logic [7:0] u, logic l);
    exp_q.push_back('{d: d, u: u, l: l});
  endfunction

  function automatic void push_term(logic [2:0] code);
    push_beat(16'h0000, {5'b11000, code}, 1'b1);
    in_msg = 1'b0;
  endfunction

  function automatic void model_idle(int n);
    idle_acc += n;
    if (in_msg && idle_acc >= GAP) push_term(3'd3);
  endfunction

  function automatic void model_word(logic [15:0] d, logic [7:0] u);
    idle_acc = 0;
    if (!in_msg) begin
      if (!u[2] && u[1:0] == 2'b01 && (d[15:11] == 5'd1 || d[15:11] == 5'd31)) begin
        if (d[10]) begin
          push_beat(d, 8'h80, 1'b1);
        end else begin
          push_beat(d, 8'h40, 1'b0);
          rem    = (d[4:0] == 5'd0) ? 32 : int'(d[4:0]);
          in_msg = 1'b1;
        end
      end
    end else if (u[2]) begin
      push_term(3'd1);
    end else if (u[1:0] == 2'b10) begin
      rem--;
      push_beat(d, 8'h00, rem == 0);
      if (rem == 0) in_msg = 1'b0;
    end else begin
      push_term(3'd2);
    end
  endfunction

  // ---- stimulus ----
  task automatic idle(int n);
    model_idle(n);
    s_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic send(logic [15:0] d, logic [7:0] u, int n_idle);
    int w;
    bit hs;
    idle(n_idle);
    model_word(d, u);
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    w  = 0;
    hs = 1'b0;
    while (!hs) begin
      @(negedge aclk);
      hs = s_tready;
      @(posedge aclk); #1;
      w++;
      if (!hs && w > 2000) begin
        vectors++;
        note_fail("accept_timeout", {16'h0, d}, 32'h1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    arstn    = 1'b0;
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_pulses", {msg_done, msg_error}, 0);
    exp_q.delete();
    in_msg   = 1'b0;
    idle_acc = 0;
    @(posedge aclk); #1;
    arstn = 1'b1;
  endtask

  task automatic scenario1();
    send(16'h0822, 8'h01, 0);
    send(16'h1234, 8'h02, 0);
    send(16'hABCD, 8'h02, 0);
  endtask

  // ---- downstream ready: random backpressure or a forced low window ----
  initial begin
    forever begin
      @(posedge aclk); #1;
      if (cyc < lo_until) m_tready = 1'b0;
      else if (bp_en)     m_tready = ($urandom_range(0, 3) != 0);
      else                m_tready = 1'b1;
    end
  end

  // ---- monitor ----
  bit    prev_stall = 1'b0;
  beat_t mon_e;

  always @(negedge aclk) begin
    if (!arstn) begin
      prev_stall = 1'b0;
    end else begin
      if (m_tvalid && !prev_stall) begin
        if (exp_q.size() == 0) begin
          vectors++;
          note_fail("unexpected_beat", {m_tuser, m_tdata}, 32'h0);
        end else begin
          mon_e = exp_q[0];
          chk("msg_done", msg_done, (mon_e.l && mon_e.u[7:6] != 2'b11) ? 1 : 0);
          chk("msg_error", msg_error, (mon_e.u[7:6] == 2'b11) ? 1 : 0);
        end
      end else if (msg_done || msg_error) begin
        vectors++;
        note_fail("stray_pulse", {msg_done, msg_error}, 32'h0);
      end
      if (m_tvalid && m_tready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("beat_tdata", m_tdata, mon_e.d);
        chk("beat_tuser", m_tuser, mon_e.u);
        chk("beat_tlast", m_tlast, mon_e.l);
      end
      prev_stall = m_tvalid && !m_tready;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got 0x%0h cycles, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---- main sequence ----
  initial begin
    logic [4:0]  addr;
    logic        tr;
    logic [4:0]  sa;
    logic [4:0]  wc;
    logic [15:0] d;
    logic [7:0]  u;
    logic        par;
    int          n;
    int          w;

    do_reset();
    idle(2);

    // basic receive message
    scenario1();
    idle(5);

    // word count 0 means 32
    send(16'h0820, 8'h01, 0);
    for (int i = 0; i < 32; i++) send(16'(i * 16'h0101 + 16'h5A00), 8'h02, 0);
    idle(5);

    // foreign RT filtered, then broadcast accepted
    send(16'h1021, 8'h01, 0);
    send(16'h7777, 8'h02, 0);
    send(16'hF821, 8'h01, 1);
    send(16'h2222, 8'h02, 0);
    idle(5);

    // parity error mid-message
    send(16'h0822, 8'h01, 0);
    send(16'h1111, 8'h02, 0);
    send(16'h3333, 8'h06, 0);
    idle(5);

    // gap timeout and unexpected command sync
    send(16'h0823, 8'h01, 0);
    send(16'h4444, 8'h02, 0);
    idle(401);
    send(16'h0822, 8'h01, 0);
    send(16'h5555, 8'h02, 0);
    send(16'h0822, 8'h01, 0);
    idle(5);

    // gap one short of the limit, then exactly at the limit
    send(16'h0822, 8'h01, 0);
    send(16'h6666, 8'h02, GAP - 1);
    send(16'h6667, 8'h02, GAP - 1);
    send(16'h0821, 8'h01, 0);
    send(16'h7777, 8'h02, GAP);
    idle(5);

    // transmit command
    send(16'h0C21, 8'h01, 0);
    idle(3);

    // long downstream stall: no loss, reorder or timeout
    lo_until = cyc + 10;
    scenario1();
    idle(20);

    // reset mid-message, then a clean command
    send(16'h0822, 8'h01, 0);
    send(16'h1111, 8'h02, 0);
    do_reset();
    send(16'h0C21, 8'h01, 0);
    idle(5);

    // randomized traffic with backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      par = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) < 25) begin
        case ($urandom_range(0, 4))
          3:       addr = 5'd2;
          4:       addr = 5'd31;
          default: addr = 5'd1;
        endcase
        tr = ($urandom_range(0, 3) == 0);
        sa = 5'($urandom);
        wc = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
        d  = {addr, tr, sa, wc};
        u  = {5'($urandom), par, 2'b01};
      end else begin
        d = 16'($urandom);
        u = {5'($urandom), par, 2'b10};
      end
      n = ($urandom_range(0, 39) == 0) ? (GAP - 2 + int'($urandom_range(0, 3)))
                                       : int'($urandom_range(0, 2));
      send(d, u, n);
    end
    idle(GAP + 20);

    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(posedge aclk); #1;
      w++;
    end
    chk("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/util_axis_1553_rx_sequencer.md
Name: util_axis_1553_rx_sequencer

Overview:
Remote-terminal receive sequencer that sits directly downstream of the 1553 decoder's AXIS word output.
- Filters command words by RT address.
- Frames each accepted message (command plus word-count data words) into one AXIS packet with tlast.
- Enforces the inter-word gap timeout.
- Terminates malformed messages with a tagged terminator beat.
Feeds the RT subaddress buffer/APB register logic.

Parameters:
clock_speed, 100000000, aclk frequency in Hz.
rt_address, 1, 5-bit RT address this terminal answers to.
broadcast_en, 1, when 1, RT address 31 is also accepted.
gap_timeout_us, 4, maximum idle gap between words of one message, in microseconds.

Ports:
aclk  in  1  system clock, rising edge.
arstn  in  1  asynchronous active-low reset.
s_axis_tdata  in  16  decoded 1553 word.
s_axis_tvalid  in  1  word valid.
s_axis_tuser  in  8  [1:0] sync type (01 = cmd/status, 10 = data); [2] parity error; [7:3] ignored.
s_axis_tready  out  1  word accept.
m_axis_tdata  out  16  framed word.
m_axis_tvalid  out  1  output valid.
m_axis_tuser  out  8  [7:6] beat type (00 data, 01 rx command, 10 tx command, 11 terminator); [5:3] 0; [2:0] error code (0 none, 1 parity, 2 unexpected sync, 3 timeout).
m_axis_tlast  out  1  last beat of message.
m_axis_tready  in  1  downstream accept.
msg_done  out  1  one-cycle pulse: good message completed.
msg_error  out  1  one-cycle pulse: message terminated with error.

Behaviour:
Reset (arstn low, asynchronous):
- All outputs 0, state IDLE, counters 0.
- A reset mid-message discards the partial message; no terminator is emitted.

Handshake:
- A word is accepted when s_axis_tvalid && s_axis_tready.
- Output is a single register stage, loadable when (!m_axis_tvalid || m_axis_tready).
- An accepted word appears on m_axis the next cycle.
- m_axis holds stable while tvalid && !tready.

Command word fields: [15:11] RT address, [10] T/R, [9:5] subaddress, [4:0] word count (0 means 32). Internal remaining-word counter is 6 bits.

IDLE:
- s_axis_tready = output loadable.
- Discard data-sync words and parity-error words.
- Discard cmd-sync words whose address does not match (match means rt_address, or 31 with broadcast_en=1).
- Matching cmd word with T/R=0: forward it (tuser 0x40, tlast 0), load count, clear gap timer, go RX_DATA.
- Matching cmd word with T/R=1: forward it (tuser 0x80, tlast 1), pulse msg_done, stay IDLE.

RX_DATA:
- s_axis_tready = output loadable.
- Good data-sync word: forward it (tuser 0x00) and decrement count.
  - When count reaches 0: tlast 1, pulse msg_done, go IDLE.
- Parity-error word: drop it, set err=1, go ERR.
- Cmd-sync word: drop it, set err=2, go ERR.
- Gap timer:
  - Counts while s_axis_tvalid is low and clears on every accepted word. Downstream backpressure never causes a timeout.
  - Terminal count is gap_cycles = (clock_speed/1000000)*gap_timeout_us.
  - Reaching the terminal count sets err=3 and goes ERR.

ERR:
- s_axis_tready = 0.
- When output is loadable, emit terminator beat: tdata 0x0000, tuser {2'b11, 3'b000, err}, tlast 1.
- Pulse msg_error in the same cycle as the load, then go IDLE.

General rules:
- msg_done and msg_error pulse in the cycle the tlast beat is loaded and are never asserted together.
- Simultaneous timeout terminal count and word acceptance: the accepted word wins and the timer clears.
- Every packet on m_axis ends with exactly one tlast.

Test Plan:
1. Word 0x0822 (cmd sync), then 0x1234 and 0xABCD (data sync) -> 3 beats: 0x0822/tuser 0x40, 0x1234/0x00, 0xABCD/0x00 with tlast on the third; msg_done pulses once.
2. Command 0x0820 (wc=0) followed by 32 data words -> 33 beats, tlast only on beat 33; msg_done once.
3. Command 0x1021 (RT 2) plus 1 data word -> all words accepted (tready high), no m_axis output. Repeat with 0xF821 and broadcast_en=1 -> forwarded.
4. Command 0x0822, data 0x1111, then data word with tuser[2]=1 -> beats 0x0822, 0x1111, then terminator 0x0000/tuser 0xC1/tlast; msg_error pulses once.
5. Command 0x0823, one data word, then 401 idle cycles (defaults) -> terminator tuser 0xC3 after 400 idle cycles; cmd word mid-message -> terminator 0xC2.
6. Transmit cmd 0x0C21 -> single beat with tuser 0x80 and tlast. Scenario 1 with m_axis_tready low for 10 cycles -> no loss or reorder, no timeout. arstn low mid-message -> all outputs 0, next command framed cleanly.
